// File: rtl/pwm_sched.sv
// pwm_sched: shared 15-bit timebase for a bank of pwm channels, plus a
// sequencer that turns one host register request at a time into a
// chip-select access on the shared channel data bus. Sync writes are held
// until the period wraps so duty updates land on a period boundary.

module pwm_sched #(
    parameter int          NCH     = 4,
    parameter int          CHW     = 2,
    parameter logic [14:0] PERIOD  = 15'd32767,
    parameter int          ACC_CYC = 3
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            run,
    output logic [14:0]     counter,
    output logic            tick,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [CHW-1:0]  req_ch,
    input  logic            req_wr,
    input  logic            req_sync,
    input  logic [15:0]     req_wdata,
    output logic            rsp_valid,
    output logic [15:0]     rsp_rdata,
    output logic            rsp_err,
    output logic [NCH-1:0]  cs,
    output logic            rd,
    output logic [15:0]     data_out,
    output logic            data_oe,
    input  logic [15:0]     data_in
);

    typedef enum logic [1:0] {IDLE, WAIT_WRAP, ACCESS, GAP} state_t;

    // Channel numbers at or above NCH have no pwm instance behind them.
    localparam logic [CHW:0] NCH_LIM  = (CHW + 1)'(NCH);
    localparam logic [3:0]   ACC_LAST = 4'(ACC_CYC - 1);

    state_t         state;
    state_t         state_nxt;
    logic [CHW-1:0] lat_ch;
    logic           lat_wr;
    logic [15:0]    lat_wdata;
    logic [3:0]     acc_cnt;
    logic [15:0]    cap_data;
    logic           req_oob;
    logic           lat_oob;
    logic           acc_last;
    logic           in_access;
    logic           handshake;

    assign tick      = run && (counter == PERIOD);
    assign req_oob   = {1'b0, req_ch} >= NCH_LIM;
    assign lat_oob   = {1'b0, lat_ch} >= NCH_LIM;
    assign acc_last  = (acc_cnt == ACC_LAST);
    assign in_access = (state == ACCESS);
    assign handshake = (state == IDLE) && req_valid;

    // Free-running timebase that wraps at PERIOD and freezes when run is low.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            counter <= 15'd0;
        end else if (run) begin
            counter <= (counter == PERIOD) ? 15'd0 : counter + 15'd1;
        end
    end

    // Sequencer state register; reset drops cs at once because cs decodes from it.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold the accepted request for the whole transaction (only one in flight).
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            lat_ch    <= '0;
            lat_wr    <= 1'b0;
            lat_wdata <= 16'd0;
        end else if (handshake) begin
            lat_ch    <= req_ch;
            lat_wr    <= req_wr;
            lat_wdata <= req_wdata;
        end
    end

    // Count cycles spent in ACCESS so cs is held for exactly ACC_CYC cycles.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            acc_cnt <= 4'd0;
        end else if (in_access) begin
            acc_cnt <= acc_cnt + 4'd1;
        end else begin
            acc_cnt <= 4'd0;
        end
    end

    // Sample the channel bus on the final access cycle of a read.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            cap_data <= 16'd0;
        end else if (in_access && acc_last && !lat_wr) begin
            cap_data <= data_in;
        end
    end

    // Next-state selection and all bus/response outputs decoded from state.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 16'd0;
        cs        = '0;
        rd        = 1'b0;
        data_oe   = 1'b0;
        data_out  = 16'd0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_wr && req_sync && run) begin
                        state_nxt = WAIT_WRAP;
                    end else if (req_oob) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt = ACCESS;
                    end
                end
            end
            WAIT_WRAP: begin
                if (lat_oob) begin
                    state_nxt = GAP;
                end else if (tick || !run) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                for (int i = 0; i < NCH; i++) begin
                    cs[i] = (lat_ch == CHW'(i));
                end
                rd      = !lat_wr;
                data_oe = lat_wr;
                if (lat_wr) begin
                    data_out = lat_wdata;
                end
                if (acc_last) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                rsp_valid = 1'b1;
                rsp_err   = lat_oob;
                if (!lat_wr && !lat_oob) begin
                    rsp_rdata = cap_data;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_sched.sv
// tb_pwm_sched: drives directed and random host requests into pwm_sched and
// compares every cycle against a timeline-based reference model. A second
// instance with PERIOD=1 exercises the shortest timebase.

module tb_pwm_sched;

    localparam int          NCH = 3;
    localparam int          CHW = 2;
    localparam int          ACC = 3;
    localparam logic [14:0] PER = 15'd9;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic            rst;
    logic            run;
    logic [14:0]     counter;
    logic            tick;
    logic            req_valid;
    logic            req_ready;
    logic [CHW-1:0]  req_ch;
    logic            req_wr;
    logic            req_sync;
    logic [15:0]     req_wdata;
    logic            rsp_valid;
    logic [15:0]     rsp_rdata;
    logic            rsp_err;
    logic [NCH-1:0]  cs;
    logic            rd;
    logic [15:0]     data_out;
    logic            data_oe;
    logic [15:0]     data_in;

    logic [14:0]     p1_counter;
    logic            p1_tick;
    logic            p1_req_ready;
    logic            p1_rsp_valid;
    logic [15:0]     p1_rsp_rdata;
    logic            p1_rsp_err;
    logic [0:0]      p1_cs;
    logic            p1_rd;
    logic [15:0]     p1_data_out;
    logic            p1_data_oe;
    logic            p1_zero = 1'b0;
    logic [0:0]      p1_ch = 1'b0;
    logic [15:0]     p1_zero16 = 16'd0;

    pwm_sched #(.NCH(NCH), .CHW(CHW), .PERIOD(PER), .ACC_CYC(ACC)) dut (
        .sys_clk(sys_clk), .rst(rst), .run(run), .counter(counter), .tick(tick),
        .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch),
        .req_wr(req_wr), .req_sync(req_sync), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cs(cs), .rd(rd), .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
    );

    pwm_sched #(.NCH(1), .CHW(1), .PERIOD(15'd1), .ACC_CYC(2)) dut_p1 (
        .sys_clk(sys_clk), .rst(rst), .run(run), .counter(p1_counter), .tick(p1_tick),
        .req_valid(p1_zero), .req_ready(p1_req_ready), .req_ch(p1_ch),
        .req_wr(p1_zero), .req_sync(p1_zero), .req_wdata(p1_zero16),
        .rsp_valid(p1_rsp_valid), .rsp_rdata(p1_rsp_rdata), .rsp_err(p1_rsp_err),
        .cs(p1_cs), .rd(p1_rd), .data_out(p1_data_out), .data_oe(p1_data_oe), .data_in(p1_zero16)
    );

    // Channel register bank: latches bus writes, returns contents on reads.
    logic [15:0] chan_regs [NCH];

    always @(posedge sys_clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (cs[i] && data_oe) chan_regs[i] <= data_out;
        end
    end

    always_comb begin
        data_in = 16'hBAD0;
        for (int i = 0; i < NCH; i++) begin
            if (cs[i] && rd) data_in = chan_regs[i];
        end
    end

    int vectors;
    int miscompares;

    // Reference model: counter arithmetic plus a per-request cycle timeline.
    int          cyc;
    logic [14:0] m_cnt;
    logic [14:0] m1_cnt;
    bit          busy;
    bit          m_wait;
    bit          m_acc_known;
    bit          m_err;
    bit          m_wr;
    logic [1:0]  m_ch;
    logic [15:0] m_wdata;
    int          acc_start;
    int          rsp_cyc;
    logic [15:0] model_regs [NCH];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic modelReset();
        m_cnt       = 15'd0;
        m1_cnt      = 15'd0;
        busy        = 1'b0;
        m_wait      = 1'b0;
        m_acc_known = 1'b0;
        m_err       = 1'b0;
        acc_start   = -1;
        rsp_cyc     = -1;
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance model.
    task automatic applyStimulus(input bit i_run, input bit i_valid, input logic [1:0] i_ch,
                                 input bit i_wr, input bit i_sync, input logic [15:0] i_wdata);
        bit          e_tick;
        bit          e1_tick;
        bit          e_ready;
        bit          e_acc;
        bit          e_rsp;
        logic [2:0]  e_cs;
        logic [15:0] e_rdata;
        bit          hs;
        @(posedge sys_clk);
        #1;
        run       = i_run;
        req_valid = i_valid;
        req_ch    = i_ch;
        req_wr    = i_wr;
        req_sync  = i_sync;
        req_wdata = i_wdata;
        #1;
        e_tick  = i_run && (m_cnt == PER);
        e1_tick = i_run && (m1_cnt == 15'd1);
        e_ready = !busy;
        e_acc   = busy && m_acc_known && (cyc >= acc_start) && (cyc < acc_start + ACC);
        e_rsp   = busy && (cyc == rsp_cyc);
        e_cs    = e_acc ? (3'b001 << m_ch) : 3'b000;
        e_rdata = (e_rsp && !m_err && !m_wr) ? model_regs[m_ch] : 16'd0;

        checkOutput("counter",   32'(counter),   32'(m_cnt));
        checkOutput("tick",      32'(tick),      32'(e_tick));
        checkOutput("req_ready", 32'(req_ready), 32'(e_ready));
        checkOutput("cs",        32'(cs),        32'(e_cs));
        checkOutput("rd",        32'(rd),        32'(e_acc && !m_wr));
        checkOutput("data_oe",   32'(data_oe),   32'(e_acc && m_wr));
        checkOutput("data_out",  32'(data_out),  (e_acc && m_wr) ? 32'(m_wdata) : 32'd0);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        checkOutput("rsp_err",   32'(rsp_err),   32'(e_rsp && m_err));
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
        checkOutput("p1_counter", 32'(p1_counter), 32'(m1_cnt));
        checkOutput("p1_tick",    32'(p1_tick),    32'(e1_tick));

        hs = e_ready && i_valid;
        if (busy && m_wait && (e_tick || !i_run)) begin
            m_wait      = 1'b0;
            m_acc_known = 1'b1;
            acc_start   = cyc + 1;
            rsp_cyc     = acc_start + ACC;
        end
        if (e_rsp) begin
            if (m_wr && !m_err) model_regs[m_ch] = m_wdata;
            busy = 1'b0;
        end
        if (hs) begin
            busy        = 1'b1;
            m_ch        = i_ch;
            m_wr        = i_wr;
            m_wdata     = i_wdata;
            m_err       = (int'(i_ch) >= NCH);
            m_wait      = 1'b0;
            m_acc_known = 1'b0;
            rsp_cyc     = -1;
            if (i_wr && i_sync && i_run) begin
                m_wait = 1'b1;
            end else if (m_err) begin
                rsp_cyc = cyc + 1;
            end else begin
                m_acc_known = 1'b1;
                acc_start   = cyc + 1;
                rsp_cyc     = cyc + 1 + ACC;
            end
        end
        if (i_run) begin
            m_cnt  = (m_cnt == PER) ? 15'd0 : m_cnt + 15'd1;
            m1_cnt = (m1_cnt == 15'd1) ? 15'd0 : 15'd1;
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit i_run);
        for (int k = 0; k < n; k++) applyStimulus(i_run, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic waitDone(input bit i_run);
        int k;
        k = 0;
        while (busy && k < 64) begin
            applyStimulus(i_run, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
            k++;
        end
        if (busy) checkOutput("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic waitCount(input logic [14:0] target);
        int k;
        k = 0;
        while (m_cnt != target && k < 40) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
            k++;
        end
        if (m_cnt != target) checkOutput("count_timeout", 32'd1, 32'd0);
    endtask

    task automatic checkReset();
        checkOutput("rst_counter",   32'(counter),   32'd0);
        checkOutput("rst_tick",      32'(tick),      32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_cs",        32'(cs),        32'd0);
        checkOutput("rst_rd",        32'(rd),        32'd0);
        checkOutput("rst_data_oe",   32'(data_oe),   32'd0);
        checkOutput("rst_data_out",  32'(data_out),  32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        checkOutput("rst_rsp_err",   32'(rsp_err),   32'd0);
        checkOutput("rst_p1_counter", 32'(p1_counter), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          r_run;
        bit          r_valid;
        logic [1:0]  r_ch;
        bit          r_wr;
        bit          r_sync;
        logic [15:0] r_wdata;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst         = 1'b0;
        run         = 1'b0;
        req_valid   = 1'b0;
        req_ch      = '0;
        req_wr      = 1'b0;
        req_sync    = 1'b0;
        req_wdata   = 16'd0;
        modelReset();
        #23;
        checkReset();
        @(posedge sys_clk);
        #1;
        rst = 1'b1;

        $display("[TB] timebase run/freeze");
        idle(14, 1'b1);
        idle(4, 1'b0);

        $display("[TB] writes and throughput");
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 16'h00A5);
        waitDone(1'b1);
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 16'h1235);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 16'h0F0F);
        waitDone(1'b1);

        $display("[TB] read channel 1");
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 16'd0);
        waitDone(1'b1);

        $display("[TB] sync writes");
        waitCount(15'd2);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 16'h5A5A);
        waitDone(1'b1);
        waitCount(PER);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 16'h7E01);
        waitDone(1'b1);
        waitCount(15'd2);
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 16'hC001);
        idle(3, 1'b1);
        waitDone(1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 16'h1111);
        waitDone(1'b0);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 16'd0);
        waitDone(1'b1);

        $display("[TB] out-of-range channel");
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 16'd0);
        waitDone(1'b1);
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 16'hFFFF);
        waitDone(1'b1);

        $display("[TB] random traffic");
        for (int n = 0; n < 800; n++) begin
            r_run   = ($urandom_range(0, 7) != 0);
            r_valid = ($urandom_range(0, 2) == 0);
            r_ch    = 2'($urandom_range(0, 3));
            r_wr    = 1'($urandom_range(0, 1));
            r_sync  = 1'($urandom_range(0, 1));
            r_wdata = 16'($urandom);
            if (int'(r_ch) >= NCH) r_sync = 1'b0;
            applyStimulus(r_run, r_valid, r_ch, r_wr, r_sync, r_wdata);
        end
        waitDone(1'b1);

        $display("[TB] reset during access");
        idle(4, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 16'hC3C3);
        idle(1, 1'b1);
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("arst_cs",        32'(cs),         32'd0);
        checkOutput("arst_data_oe",   32'(data_oe),    32'd0);
        checkOutput("arst_counter",   32'(counter),    32'd0);
        checkOutput("arst_rsp_valid", 32'(rsp_valid),  32'd0);
        checkOutput("arst_p1_counter", 32'(p1_counter), 32'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        run       = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_sync  = 1'b0;
        rst       = 1'b1;
        modelReset();
        model_regs[1] = 16'hC3C3;
        idle(3, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 16'd0);
        waitDone(1'b1);
        idle(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
